// File: rtl/nmea_field_extractor.sv
// nmea_field_extractor
//   Parses NMEA-0183 sentences arriving byte-by-byte from a UART receiver.
//   Matches one 5-character sentence ID, captures selected comma-separated
//   fields into right-aligned, zero-padded slots, verifies the *hh checksum
//   and publishes every slot at once only for sentences that pass.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   single-cycle strobe, in_data_i holds a received byte
//   in_data_i    received ASCII byte
//   fields_o     committed slots, slot 0 in the MSBs
//   out_valid_o  one-cycle pulse, fields_o/trunc_o just updated
//   err_o        one-cycle pulse, a matched sentence was rejected
//   trunc_o      at least one slot of the last committed sentence overflowed
//   good_cnt_o   saturating count of accepted sentences
//   err_cnt_o    saturating count of rejected sentences
module nmea_field_extractor #(
  parameter logic [39:0]              SENTENCE_ID = "GPGGA",
  parameter int                       NUM_FIELDS  = 6,
  parameter logic [NUM_FIELDS*5-1:0]  FIELD_IDX   = {5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10},
  parameter int                       MAX_CHARS   = 11,
  parameter bit                       CHECK_CSUM  = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  input  logic [7:0]                         in_data_i,
  output logic [NUM_FIELDS*MAX_CHARS*8-1:0]  fields_o,
  output logic                               out_valid_o,
  output logic                               err_o,
  output logic                               trunc_o,
  output logic [15:0]                        good_cnt_o,
  output logic [15:0]                        err_cnt_o
);

  localparam int SLOT_W = MAX_CHARS * 8;
  localparam int LEN_W  = $clog2(MAX_CHARS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);

  typedef enum logic [2:0] {IDLE, HDR, BODY, CS1, CS2} state_e;

  state_e                  state_q;
  logic [2:0]              hdrIdx_q;
  logic [7:0]              csum_q;
  logic [4:0]              fieldCnt_q;
  logic [3:0]              csHi_q;
  logic [SLOT_W-1:0]       buf_q [NUM_FIELDS];
  logic [LEN_W-1:0]        len_q [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]   slotTrunc_q;

  logic [7:0]                   idChar_d;
  logic                         isHex_d;
  logic [3:0]                   hexVal_d;
  logic                         isPrint_d;
  logic                         isEol_d;
  logic                         csumOk_d;
  logic                         startSentence_d;
  logic                         acceptEvt_d;
  logic                         rejectEvt_d;
  logic [NUM_FIELDS*SLOT_W-1:0] fieldsPacked_d;

  // Character of SENTENCE_ID expected at the current header position;
  // character 0 sits in the MSBs of the parameter.
  always_comb begin
    idChar_d = 8'h00;
    case (hdrIdx_q)
      3'd0: idChar_d = SENTENCE_ID[39:32];
      3'd1: idChar_d = SENTENCE_ID[31:24];
      3'd2: idChar_d = SENTENCE_ID[23:16];
      3'd3: idChar_d = SENTENCE_ID[15:8];
      3'd4: idChar_d = SENTENCE_ID[7:0];
      default: idChar_d = 8'h00;
    endcase
  end

  // Hex digit decode; letters of either case map via their low nibble + 9.
  always_comb begin
    isHex_d  = 1'b0;
    hexVal_d = 4'h0;
    if (in_data_i >= "0" && in_data_i <= "9") begin
      isHex_d  = 1'b1;
      hexVal_d = in_data_i[3:0];
    end else if ((in_data_i >= "A" && in_data_i <= "F") ||
                 (in_data_i >= "a" && in_data_i <= "f")) begin
      isHex_d  = 1'b1;
      hexVal_d = in_data_i[3:0] + 4'd9;
    end
  end

  always_comb begin
    isPrint_d       = (in_data_i >= 8'h20) && (in_data_i <= 8'h7E);
    isEol_d         = (in_data_i == 8'h0D) || (in_data_i == 8'h0A);
    csumOk_d        = ({csHi_q, hexVal_d} == csum_q) || !CHECK_CSUM;
    startSentence_d = in_valid_i && (in_data_i == "$") &&
                      (state_q == IDLE || state_q == BODY);
    acceptEvt_d     = in_valid_i && (state_q == CS2) && isHex_d && csumOk_d;
    rejectEvt_d     = in_valid_i &&
                      (((state_q == BODY) && (isEol_d || in_data_i == "$")) ||
                       ((state_q == CS1) && !isHex_d) ||
                       ((state_q == CS2) && (!isHex_d || !csumOk_d)));
  end

  always_comb begin
    fieldsPacked_d = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      fieldsPacked_d[(NUM_FIELDS-1-k)*SLOT_W +: SLOT_W] = buf_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hdrIdx_q    <= '0;
      csum_q      <= '0;
      fieldCnt_q  <= '0;
      csHi_q      <= '0;
      slotTrunc_q <= '0;
      for (int k = 0; k < NUM_FIELDS; k++) begin
        buf_q[k] <= '0;
        len_q[k] <= '0;
      end
      fields_o    <= '0;
      out_valid_o <= 1'b0;
      err_o       <= 1'b0;
      trunc_o     <= 1'b0;
      good_cnt_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      out_valid_o <= acceptEvt_d;
      err_o       <= rejectEvt_d;

      if (acceptEvt_d) begin
        fields_o <= fieldsPacked_d;
        trunc_o  <= |slotTrunc_q;
        if (good_cnt_o != 16'hFFFF) good_cnt_o <= good_cnt_o + 16'd1;
      end
      if (rejectEvt_d && err_cnt_o != 16'hFFFF) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end

      if (in_valid_i) begin
        case (state_q)
          IDLE: ;
          HDR: begin
            csum_q <= csum_q ^ in_data_i;
            if (hdrIdx_q != 3'd5) begin
              // A foreign sentence ID is dropped without raising an error.
              if (in_data_i == idChar_d) hdrIdx_q <= hdrIdx_q + 3'd1;
              else                       state_q  <= IDLE;
            end else if (in_data_i == ",") begin
              fieldCnt_q <= 5'd1;
              state_q    <= BODY;
            end else begin
              state_q <= IDLE;
            end
          end
          BODY: begin
            if (in_data_i == "*") begin
              state_q <= CS1;
            end else if (isEol_d) begin
              state_q <= IDLE;
            end else if (in_data_i != "$") begin
              csum_q <= csum_q ^ in_data_i;
              if (in_data_i == ",") begin
                if (fieldCnt_q != 5'd31) fieldCnt_q <= fieldCnt_q + 5'd1;
              end else if (isPrint_d) begin
                // Several slots may select the same field; each captures it.
                for (int k = 0; k < NUM_FIELDS; k++) begin
                  if (fieldCnt_q == FIELD_IDX[(NUM_FIELDS-1-k)*5 +: 5]) begin
                    if (len_q[k] < MAX_LEN) begin
                      buf_q[k] <= (buf_q[k] << 8) | SLOT_W'(in_data_i);
                      len_q[k] <= len_q[k] + 1'b1;
                    end else begin
                      slotTrunc_q[k] <= 1'b1;
                    end
                  end
                end
              end
            end
          end
          CS1: begin
            if (isHex_d) begin
              csHi_q  <= hexVal_d;
              state_q <= CS2;
            end else begin
              state_q <= IDLE;
            end
          end
          CS2:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase

        // A '$' always opens a fresh sentence, including one that
        // interrupts a body in progress (that one is counted as rejected).
        if (startSentence_d) begin
          state_q     <= HDR;
          hdrIdx_q    <= '0;
          csum_q      <= '0;
          fieldCnt_q  <= '0;
          slotTrunc_q <= '0;
          for (int k = 0; k < NUM_FIELDS; k++) begin
            buf_q[k] <= '0;
            len_q[k] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_field_extractor.sv
// tb_nmea_field_extractor
//   Directed, table-driven bench for nmea_field_extractor with default
//   parameters. Each table record is a sentence body (text between '$' and
//   '*'), a mask applied to the correct checksum, the expected pulse and the
//   expected committed slots. Multi-cycle corner cases follow as hand-written
//   sequences.
module tb_nmea_field_extractor;

  localparam int FW = 6 * 11 * 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [7:0]      in_data;
  logic [FW-1:0]   fields;
  logic            out_valid;
  logic            err;
  logic            trunc;
  logic [15:0]     good_cnt;
  logic [15:0]     err_cnt;

  always #5 clk = ~clk;

  nmea_field_extractor dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .fields_o    (fields),
    .out_valid_o (out_valid),
    .err_o       (err),
    .trunc_o     (trunc),
    .good_cnt_o  (good_cnt),
    .err_cnt_o   (err_cnt)
  );

  typedef struct {
    logic [767:0]  body;
    logic [7:0]    xorMask;
    bit            lowerHex;
    int            expPulse;   // 0 none, 1 out_valid, 2 err
    logic [FW-1:0] expFields;
    bit            expTrunc;
  } vec_t;

  vec_t          vecs [7];
  int            checks = 0;
  int            errors = 0;
  int            okSeen = 0;
  int            errSeen = 0;
  int            okMark = 0;
  int            errMark = 0;
  int            expGood = 0;
  int            expErr = 0;
  logic [FW-1:0] curFields = '0;
  bit            curTrunc = 1'b0;
  logic [FW-1:0] ggaFields;
  logic [767:0]  ggaBody;

  always @(negedge clk) begin
    if (out_valid) okSeen++;
    if (err) errSeen++;
    if (out_valid && err) begin
      checks++;
      errors++;
      $display("[TB] FAIL exclusive_pulses actual=both required=at_most_one");
    end
  end

  function automatic logic [87:0] pad(input logic [87:0] s);
    return s;
  endfunction

  function automatic int bodyLen(input logic [767:0] b);
    for (int i = 95; i >= 0; i--) begin
      if (b[i*8 +: 8] != 8'h00) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic [7:0] bodyCsum(input logic [767:0] b);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 96; i++) c = c ^ b[i*8 +: 8];
    return c;
  endfunction

  function automatic logic [7:0] hexChar(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic sendText(input logic [767:0] b);
    for (int i = bodyLen(b) - 1; i >= 0; i--) sendByte(b[i*8 +: 8]);
  endtask

  task automatic applyStimulus(input logic [767:0] body, input logic [7:0] xorMask,
                               input bit lowerHex);
    logic [7:0] cs;
    cs = bodyCsum(body) ^ xorMask;
    sendByte("$");
    sendText(body);
    sendByte("*");
    sendByte(hexChar(cs[7:4], lowerHex));
    sendByte(hexChar(cs[3:0], lowerHex));
    sendByte(8'h0D);
    sendByte(8'h0A);
  endtask

  task automatic checkVal(input string name, input logic [FW-1:0] act,
                          input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int expOk, input int expEr);
    idle(4);
    #1;
    checkVal({tag, ".ok_pulses"},  FW'(okSeen - okMark),   FW'(expOk));
    checkVal({tag, ".err_pulses"}, FW'(errSeen - errMark), FW'(expEr));
    checkVal({tag, ".fields"},     fields,                 curFields);
    checkVal({tag, ".trunc"},      FW'(trunc),             FW'(curTrunc));
    checkVal({tag, ".good_cnt"},   FW'(good_cnt),          FW'(expGood));
    checkVal({tag, ".err_cnt"},    FW'(err_cnt),           FW'(expErr));
    okMark  = okSeen;
    errMark = errSeen;
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, ".fields"},    fields,          '0);
    checkVal({tag, ".out_valid"}, FW'(out_valid),  '0);
    checkVal({tag, ".err"},       FW'(err),        '0);
    checkVal({tag, ".trunc"},     FW'(trunc),      '0);
    checkVal({tag, ".good_cnt"},  FW'(good_cnt),   '0);
    checkVal({tag, ".err_cnt"},   FW'(err_cnt),    '0);
  endtask

  initial begin
    ggaBody   = "GPGGA,002454,3553.5295,N,13938.6570,E,1,05,2.2,18.3,M,39.0,M,,";
    ggaFields = {pad("3553.5295"), pad("N"), pad("13938.6570"),
                 pad("E"), pad("18.3"), pad("M")};

    vecs[0] = '{ggaBody, 8'h00, 1'b0, 1, ggaFields, 1'b0};
    vecs[1] = '{ggaBody, 8'h01, 1'b0, 2, '0, 1'b0};
    vecs[2] = '{"GPGLL,4916.45,N,12311.12,W,225444,A", 8'h00, 1'b0, 0, '0, 1'b0};
    vecs[3] = '{ggaBody, 8'h00, 1'b0, 1, ggaFields, 1'b0};
    vecs[4] = '{"GPGGA,002454,3553.529512345,N,13938.6570,E,1,05,2.2,18.3,M,39.0,M,,",
                8'h00, 1'b0, 1,
                {pad("3553.529512"), pad("N"), pad("13938.6570"),
                 pad("E"), pad("18.3"), pad("M")}, 1'b1};
    vecs[5] = '{"GPGGA,,,X,,E", 8'h00, 1'b0, 1,
                {88'h0, pad("X"), 88'h0, pad("E"), 88'h0, 88'h0}, 1'b0};
    vecs[6] = '{"GPGGA,A,BC,D,E,F,G,H,I,J,K,LL", 8'h00, 1'b1, 1,
                {pad("BC"), pad("D"), pad("E"), pad("F"), pad("J"), pad("K")}, 1'b0};

    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].body, vecs[v].xorMask, vecs[v].lowerHex);
      if (vecs[v].expPulse == 1) begin
        expGood++;
        curFields = vecs[v].expFields;
        curTrunc  = vecs[v].expTrunc;
      end else if (vecs[v].expPulse == 2) begin
        expErr++;
      end
      checkOutput($sformatf("vec%0d", v),
                  (vecs[v].expPulse == 1) ? 1 : 0,
                  (vecs[v].expPulse == 2) ? 1 : 0);
    end

    // Line ending before the checksum.
    sendByte("$"); sendText("GPGGA,1,2"); sendByte(8'h0D); sendByte(8'h0A);
    expErr++;
    checkOutput("no_csum", 0, 1);

    // Non-hex checksum character.
    sendByte("$"); sendText("GPGGA,1*Z1");
    expErr++;
    checkOutput("bad_hex", 0, 1);

    // '$' in the middle of a body restarts on the new sentence.
    sendByte("$"); sendText("GPGGA,002454,35");
    applyStimulus(ggaBody, 8'h00, 1'b0);
    expErr++;
    expGood++;
    curFields = ggaFields;
    curTrunc  = 1'b0;
    checkOutput("mid_dollar", 1, 1);

    // Reset mid-sentence discards the partial sentence silently.
    sendByte("$"); sendText("GPGGA,0024");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checkResetValues("mid_reset");
    @(negedge clk);
    rst_n     = 1'b1;
    okMark    = okSeen;
    errMark   = errSeen;
    expGood   = 0;
    expErr    = 0;
    curFields = '0;
    curTrunc  = 1'b0;
    idle(2);
    applyStimulus(ggaBody, 8'h00, 1'b0);
    expGood++;
    curFields = ggaFields;
    checkOutput("after_reset", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmea_field_extractor.md
# nmea_field_extractor

Parametrised NMEA-0183 sentence parser. It sits between the UART receiver (byte + ready strobe) and downstream position/display logic, entirely in the system clock domain. The block matches one configurable 5-character sentence ID and captures up to NUM_FIELDS selected comma-separated fields into fixed-width slots. It verifies the `*hh` checksum and publishes all slots atomically, only for sentences that pass the checksum.

## Interface
- SENTENCE_ID, default "GPGGA": 40-bit ASCII talker+type matched after `$`.
- NUM_FIELDS, default 6: number of captured slots, range 1–8.
- FIELD_IDX, default {5'd2,5'd3,5'd4,5'd5,5'd9,5'd10}: packed NUM_FIELDS×5 bits, slot 0 in the MSBs.
  - Each entry is a 1-based field number; field 1 follows the comma after the ID.
- MAX_CHARS, default 11: character capacity per slot.
- CHECK_CSUM, default 1: when 0, the checksum is parsed but not compared.
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: single-cycle strobe, `in_data` is valid.
- in_data, input, 8: received ASCII byte.
- fields, output, NUM_FIELDS×MAX_CHARS×8: committed slots, slot 0 in the MSBs.
- out_valid, output, 1: one-cycle pulse, `fields` updated.
- err, output, 1: one-cycle pulse, matched sentence rejected.
- trunc, output, 1: with `out_valid`, at least one slot overflowed.
- good_cnt, output, 16: saturating count of accepted sentences.
- err_cnt, output, 16: saturating count of rejected sentences.

## Operation
- States: IDLE, HDR, BODY, CS1, CS2.
- Bytes are consumed only on cycles with `in_valid`=1.
- IDLE
  - `$` → HDR.
  - On `$`, clear the hdr index, running XOR, field counter and all capture buffers.
- HDR
  - The byte is compared with SENTENCE_ID character `hdr_idx`, and XORed into the checksum.
  - On mismatch → IDLE silently. No error, because the sentence is not ours.
  - After 5 matches the next byte must be `,`. If so, field counter = 1 → BODY; otherwise → IDLE silently.
- BODY
  - Every byte except `*` is XORed into the checksum.
  - `,`: field counter +1, saturating at 31.
  - Any other printable byte: if the field counter equals FIELD_IDX[k] for some slot k, shift it into buffer k at the LSB end (right-aligned, zero-padded).
  - Once a slot already holds MAX_CHARS characters, further characters for it are dropped and its trunc bit is set.
  - `*` → CS1.
  - CR or LF → IDLE with an error (missing checksum).
  - `$` → counted as an error, then restart directly in HDR with buffers cleared.
- CS1 / CS2
  - Each accepts one hex digit: `0-9`, `A-F`, or `a-f`.
  - A non-hex byte → IDLE with an error.
  - After CS2, compare the received byte with the running XOR.
  - On match, or when CHECK_CSUM=0: commit. Copy all buffers to `fields`, set `trunc` = OR of slot trunc bits, pulse `out_valid`, increment `good_cnt`.
  - On mismatch: pulse `err`, increment `err_cnt`. `fields` is unchanged.
  - Either way → IDLE.
- Fields absent from a short sentence commit as all-zero slots.
- An empty field between adjacent commas commits as all-zero.
- Two FIELD_IDX entries with equal values capture identical data.
- The counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset: state IDLE; `fields`, buffers, `out_valid`, `err`, `trunc`, `good_cnt` and `err_cnt` are all 0.
- `out_valid` or `err` is asserted in the cycle after the clock edge that accepted the second checksum digit (or the aborting byte). Latency is 1 clk.
- `fields`, `trunc` and the counters update on that same edge and are stable from the `out_valid` cycle onward.
- `out_valid` and `err` are never asserted together.
- Back-to-back `in_valid` on consecutive cycles is supported. There is no backpressure.
- A byte accepted in the commit cycle is processed normally, e.g. `$` enters HDR.
- `rst_n` low mid-sentence: immediate return to reset values. The partial sentence is discarded without an error.

## Test plan
- Valid GGA: "$GPGGA,002454,3553.5295,N,13938.6570,E,1,05,2.2,18.3,M,39.0,M,,*hh", bench-computed hh, bytes every 5434 clk.
  - Expect one `out_valid`.
  - Expected slots: "3553.5295" (zero-padded to 11), "N", "13938.6570", "E", "18.3", "M".
  - Expect `good_cnt`=1, `trunc`=0.
- Same sentence with hh XOR 0x01 → `err` pulse, `fields` holds the previous value, `err_cnt`=1.
- "$GPGLL,..." then the valid GGA with back-to-back `in_valid` → GLL ignored with no `err`; GGA commits.
- Latitude "3553.529512345" (14 chars) → slot 0 = "3553.529512" (first 11 chars), `trunc`=1 with `out_valid`.
- `$` inserted mid-body, followed by a full valid sentence → one `err` then one `out_valid`, `err_cnt`=1, `good_cnt`=1.
- `rst_n` pulsed low after "$GPGGA,0024", then a valid sentence → no pulse for the partial sentence, all outputs 0 during reset, then a normal commit.
